dataram_arbiter: RTL and testbench
==================================

DATARAM_ARBITER -- requirements
Module: dataram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive core grants allowed while host is pending before host is forced; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 core_read  input  1  core read request, level, held until core_ready.
REQ-005 core_write  input  1  core write request, level, held until core_ready.
REQ-006 core_addr  input  5  core word address.
REQ-007 core_wdata  input  8  core write data.
REQ-008 core_rdata  output  8  core read data, valid in core_ready cycle, held until the next core read completes.
REQ-009 core_ready  output  1  one-cycle completion pulse to core.
REQ-010 host_req  input  1  host/debug request, level, held until host_ack.
REQ-011 host_we  input  1  host access type: 1 write, 0 read.
REQ-012 host_addr  input  5  host word address.
REQ-013 host_wdata  input  8  host write data.
REQ-014 host_rdata  output  8  host read data, valid in host_ack cycle, held until the next host read completes.
REQ-015 host_ack  output  1  one-cycle completion pulse to host.
REQ-016 read  output  1  data RAM read strobe, registered.
REQ-017 write  output  1  data RAM write strobe, registered.
REQ-018 mem_addr  output  5  data RAM address, registered.
REQ-019 mem_din  output  8  data RAM write data, registered.
REQ-020 mem_dout  input  8  data RAM read data, valid the cycle after read is asserted.
REQ-021 err  output  1  sticky flag: core_read and core_write sampled high together at a grant.

Function
REQ-022 FSM states IDLE, C_ACC, C_RSP, H_ACC, H_RSP; one access in flight at a time.
REQ-023 IDLE: core pending (core_read|core_write) and starve count < STARVE_LIMIT -> C_ACC; else host_req -> H_ACC; else core pending -> C_ACC; else stay IDLE.
REQ-024 At grant (IDLE exit edge), type, address and write data of the winner are latched into mem_addr, mem_din, read/write; requester inputs are ignored thereafter until its response.
REQ-025 C_ACC/H_ACC last exactly one cycle with exactly one of read/write high; both strobes low in every other state.
REQ-026 C_RSP/H_RSP last one cycle: for reads, mem_dout is captured into core_rdata/host_rdata; core_ready/host_ack pulses high this cycle; next state IDLE.
REQ-027 Latency: request first seen in IDLE -> strobe next cycle -> ready/ack the cycle after (3 edges from sampling); back-to-back throughput one access per 3 cycles.
REQ-028 Requester must drop its request in the cycle after its pulse; a request still high when IDLE is re-entered is a new access.
REQ-029 Starve counter, 4 bits: increments on each core grant while host_req is high, saturating at STARVE_LIMIT; clears to 0 on each host grant; unchanged otherwise.
REQ-030 Simultaneous core and host requests with starve count < STARVE_LIMIT: core wins; with count == STARVE_LIMIT: host wins.
REQ-031 core_read and core_write both high at grant: access performed as write, err set to 1, cleared only by reset.
REQ-032 Request deasserted before grant: no access, no pulse; deassertion after grant does not abort the access.

Reset
REQ-033 On reset: state IDLE; read, write, core_ready, host_ack, err = 0; mem_addr, mem_din, core_rdata, host_rdata = 0; starve count = 0.
REQ-034 Reset mid-access aborts it: strobes fall immediately, no ready/ack pulse is produced; after release the FSM samples requests afresh from IDLE.

Verification
REQ-035 Core read addr 5'h03, RAM returns 8'hA5: read high in cycle 2, core_ready and core_rdata=8'hA5 in cycle 3, host outputs untouched.
REQ-036 Host write addr 5'h1F data 8'h3C, core idle: write=1, mem_addr=5'h1F, mem_din=8'h3C for one cycle, then host_ack pulse.
REQ-037 Core and host both continuously requesting, STARVE_LIMIT=4: grant order C,C,C,C,H,C,C,C,C,H; no host starvation.
REQ-038 core_read=core_write=1 addr 5'h07 data 8'h11: write performed, err=1 persists across later accesses until reset.
REQ-039 Assert reset during C_ACC: read drops asynchronously, no core_ready; after release a held core request is re-granted with full 3-cycle latency.

Source files
------------

// File: rtl/dataram_arbiter.sv
// dataram_arbiter
//   Shares one single-port data RAM between the core and a host/debug port.
//   One access is in flight at a time; each access takes three cycles
//   (IDLE sample, ACC strobe, RSP pulse). The core normally has priority,
//   but after STARVE_LIMIT consecutive core grants made while the host was
//   waiting, the host is granted next.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   core_read/core_write  : core request (level, held until core_ready)
//   core_addr/core_wdata  : core address / write data
//   core_rdata/core_ready : core read data / one-cycle completion pulse
//   host_req/host_we      : host request (level) and type (1 = write)
//   host_addr/host_wdata  : host address / write data
//   host_rdata/host_ack   : host read data / one-cycle completion pulse
//   read/write            : registered RAM strobes
//   mem_addr/mem_din      : registered RAM address / write data
//   mem_dout              : RAM read data, valid the cycle after read
//   err                   : sticky, core_read and core_write high together at grant
module dataram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       core_read,
    input  logic       core_write,
    input  logic [4:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic [7:0] core_rdata,
    output logic       core_ready,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [4:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       host_ack,
    output logic       read,
    output logic       write,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout,
    output logic       err
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        C_ACC,
        C_RSP,
        H_ACC,
        H_RSP
    } state_t;

    state_t     state_reg;
    logic [3:0] starve_reg;
    logic       acc_read_reg;   // access in flight is a read
    logic [7:0] core_rdata_reg;
    logic [7:0] host_rdata_reg;

    logic core_pending;
    logic grant_core;
    logic grant_host;

    assign core_pending = core_read | core_write;
    // Core wins unless the host has been passed over STARVE_LIMIT times.
    assign grant_core   = core_pending && ((starve_reg < LIMIT) || !host_req);
    assign grant_host   = host_req && !grant_core;

    // RAM data only becomes valid in the RSP cycle, so read data is passed
    // straight through during the pulse and held from a register afterwards.
    assign core_rdata = (state_reg == C_RSP && acc_read_reg) ? mem_dout : core_rdata_reg;
    assign host_rdata = (state_reg == H_RSP && acc_read_reg) ? mem_dout : host_rdata_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            starve_reg     <= 4'd0;
            acc_read_reg   <= 1'b0;
            core_rdata_reg <= 8'd0;
            host_rdata_reg <= 8'd0;
            core_ready     <= 1'b0;
            host_ack       <= 1'b0;
            read           <= 1'b0;
            write          <= 1'b0;
            mem_addr       <= 5'd0;
            mem_din        <= 8'd0;
            err            <= 1'b0;
        end else begin
            // Strobes and pulses are single-cycle unless set below.
            core_ready <= 1'b0;
            host_ack   <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (grant_core) begin
                        state_reg    <= C_ACC;
                        mem_addr     <= core_addr;
                        mem_din      <= core_wdata;
                        // A simultaneous read+write is performed as a write.
                        write        <= core_write;
                        read         <= ~core_write;
                        acc_read_reg <= ~core_write;
                        if (core_read && core_write) begin
                            err <= 1'b1;
                        end
                        if (host_req && (starve_reg < LIMIT)) begin
                            starve_reg <= starve_reg + 4'd1;
                        end
                    end else if (grant_host) begin
                        state_reg    <= H_ACC;
                        mem_addr     <= host_addr;
                        mem_din      <= host_wdata;
                        write        <= host_we;
                        read         <= ~host_we;
                        acc_read_reg <= ~host_we;
                        starve_reg   <= 4'd0;
                    end
                end
                C_ACC: begin
                    state_reg  <= C_RSP;
                    core_ready <= 1'b1;
                end
                C_RSP: begin
                    state_reg <= IDLE;
                    if (acc_read_reg) begin
                        core_rdata_reg <= mem_dout;
                    end
                end
                H_ACC: begin
                    state_reg <= H_RSP;
                    host_ack  <= 1'b1;
                end
                H_RSP: begin
                    state_reg <= IDLE;
                    if (acc_read_reg) begin
                        host_rdata_reg <= mem_dout;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dataram_arbiter.sv
module tb_dataram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       core_read = 1'b0;
    logic       core_write = 1'b0;
    logic [4:0] core_addr = 5'd0;
    logic [7:0] core_wdata = 8'd0;
    logic [7:0] core_rdata;
    logic       core_ready;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [4:0] host_addr = 5'd0;
    logic [7:0] host_wdata = 8'd0;
    logic [7:0] host_rdata;
    logic       host_ack;
    logic       read;
    logic       write;
    logic [4:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout = 8'd0;
    logic       err;

    int total = 0;
    int bad = 0;

    logic [7:0] ram [0:31];

    dataram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_read  (core_read),
        .core_write (core_write),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .read       (read),
        .write      (write),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Simple RAM: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (write) ram[mem_addr] <= mem_din;
        if (read)  mem_dout <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({read, write, core_ready, host_ack, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {read, write, core_ready, host_ack, err});
        end
        total++;
        if (mem_addr !== 5'd0 || mem_din !== 8'd0) begin
            bad++;
            $display("FAIL reset_mem: got addr=%h din=%h want 00/00", mem_addr, mem_din);
        end
        total++;
        if (core_rdata !== 8'd0 || host_rdata !== 8'd0) begin
            bad++;
            $display("FAIL reset_rdata: got core=%h host=%h want 00/00", core_rdata, host_rdata);
        end
        reset = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_core_read();
        core_read = 1'b1;
        core_addr = 5'h03;
        step();
        total++;
        if (read !== 1'b1 || write !== 1'b0 || mem_addr !== 5'h03 || core_ready !== 1'b0) begin
            bad++;
            $display("FAIL core_read_acc: got r=%b w=%b addr=%h rdy=%b want 1 0 03 0", read, write, mem_addr, core_ready);
        end
        step();
        total++;
        if (core_ready !== 1'b1 || core_rdata !== 8'hA5 || read !== 1'b0) begin
            bad++;
            $display("FAIL core_read_rsp: got rdy=%b rdata=%h r=%b want 1 a5 0", core_ready, core_rdata, read);
        end
        total++;
        if (host_ack !== 1'b0 || host_rdata !== 8'h00) begin
            bad++;
            $display("FAIL core_read_host: got ack=%b hrdata=%h want 0 00", host_ack, host_rdata);
        end
        core_read = 1'b0;
        step();
        total++;
        if (core_ready !== 1'b0 || core_rdata !== 8'hA5) begin
            bad++;
            $display("FAIL core_read_hold: got rdy=%b rdata=%h want 0 a5", core_ready, core_rdata);
        end
        $display("test_core_read: addr=03 rdata=%h", core_rdata);
    endtask

    task automatic test_host_write();
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = 5'h1F;
        host_wdata = 8'h3C;
        step();
        total++;
        if (write !== 1'b1 || read !== 1'b0 || mem_addr !== 5'h1F || mem_din !== 8'h3C) begin
            bad++;
            $display("FAIL host_write_acc: got w=%b r=%b addr=%h din=%h want 1 0 1f 3c", write, read, mem_addr, mem_din);
        end
        step();
        total++;
        if (host_ack !== 1'b1 || write !== 1'b0 || core_ready !== 1'b0) begin
            bad++;
            $display("FAIL host_write_rsp: got ack=%b w=%b rdy=%b want 1 0 0", host_ack, write, core_ready);
        end
        host_req = 1'b0;
        step();
        total++;
        if (host_ack !== 1'b0 || write !== 1'b0) begin
            bad++;
            $display("FAIL host_write_idle: got ack=%b w=%b want 0 0", host_ack, write);
        end
        $display("test_host_write: addr=1f data=3c");
    endtask

    task automatic test_host_read();
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 5'h1F;
        step();
        total++;
        if (read !== 1'b1 || mem_addr !== 5'h1F) begin
            bad++;
            $display("FAIL host_read_acc: got r=%b addr=%h want 1 1f", read, mem_addr);
        end
        step();
        total++;
        if (host_ack !== 1'b1 || host_rdata !== 8'h3C || core_rdata !== 8'hA5) begin
            bad++;
            $display("FAIL host_read_rsp: got ack=%b hrdata=%h crdata=%h want 1 3c a5", host_ack, host_rdata, core_rdata);
        end
        host_req = 1'b0;
        step();
        $display("test_host_read: addr=1f rdata=%h", host_rdata);
    endtask

    task automatic test_fairness();
        logic exp_host [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        core_read = 1'b1;
        core_addr = 5'h00;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 5'h01;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (mem_addr !== (exp_host[i] ? 5'h01 : 5'h00) || read !== 1'b1) begin
                bad++;
                $display("FAIL fair_grant%0d: got addr=%h r=%b want addr=%h r=1", i, mem_addr, read, exp_host[i] ? 5'h01 : 5'h00);
            end
            step();
            total++;
            if (host_ack !== exp_host[i] || core_ready !== !exp_host[i]) begin
                bad++;
                $display("FAIL fair_pulse%0d: got ack=%b rdy=%b want ack=%b", i, host_ack, core_ready, exp_host[i]);
            end
            $display("test_fairness: grant %0d to %s", i, exp_host[i] ? "host" : "core");
            step();
        end
        core_read = 1'b0;
        host_req = 1'b0;
        step();
    endtask

    task automatic test_err();
        core_read = 1'b1;
        core_write = 1'b1;
        core_addr = 5'h07;
        core_wdata = 8'h11;
        step();
        total++;
        if (write !== 1'b1 || read !== 1'b0 || mem_addr !== 5'h07 || mem_din !== 8'h11 || err !== 1'b1) begin
            bad++;
            $display("FAIL err_acc: got w=%b r=%b addr=%h din=%h err=%b want 1 0 07 11 1", write, read, mem_addr, mem_din, err);
        end
        step();
        core_read = 1'b0;
        core_write = 1'b0;
        step();
        // Read back through the core: data proves the write happened.
        core_read = 1'b1;
        step();
        step();
        total++;
        if (core_ready !== 1'b1 || core_rdata !== 8'h11 || err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got rdy=%b rdata=%h err=%b want 1 11 1", core_ready, core_rdata, err);
        end
        core_read = 1'b0;
        step();
        $display("test_err: err=%b rdata=%h", err, core_rdata);
    endtask

    task automatic test_withdraw();
        core_read = 1'b1;
        core_addr = 5'h03;
        #3;
        core_read = 1'b0;
        step();
        total++;
        if (read !== 1'b0 || write !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_acc: got r=%b w=%b want 0 0", read, write);
        end
        step();
        total++;
        if (core_ready !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_pulse: got rdy=%b want 0", core_ready);
        end
        $display("test_withdraw: no access");
    endtask

    task automatic test_reset_mid();
        core_read = 1'b1;
        core_addr = 5'h03;
        step();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (read !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_async: got r=%b err=%b want 0 0", read, err);
        end
        step();
        total++;
        if (core_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_pulse: got rdy=%b want 0", core_ready);
        end
        reset = 1'b0;
        step();
        total++;
        if (read !== 1'b1 || core_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_regrant: got r=%b rdy=%b want 1 0", read, core_ready);
        end
        step();
        total++;
        if (core_ready !== 1'b1 || core_rdata !== 8'hA5) begin
            bad++;
            $display("FAIL rst_mid_rsp: got rdy=%b rdata=%h want 1 a5", core_ready, core_rdata);
        end
        core_read = 1'b0;
        step();
        $display("test_reset_mid: regrant rdata=%h", core_rdata);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        ram[3] = 8'hA5;
        test_reset();
        test_core_read();
        test_host_write();
        test_host_read();
        test_fairness();
        test_err();
        test_withdraw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
